// File: rtl/alu_writeback.sv
// Writeback stage after the 20-bit ALU: drives the register-file write port,
// owns the status register and splits swap results into two back-to-back writes.
module alu_writeback #(
    parameter int AW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic          in_mode,
    input  logic [AW-1:0] in_dst_a,
    input  logic [AW-1:0] in_dst_b,
    input  logic [19:0]   in_res_a,
    input  logic [19:0]   in_res_b,
    input  logic          in_zero,
    input  logic          in_sign,
    input  logic          in_carry,
    input  logic [2:0]    in_flag_mask,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [19:0]   wr_data,
    output logic [2:0]    sr,
    output logic          illegal,
    output logic [CW-1:0] retire_cnt
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    localparam logic [2:0] OP_WR_ONE     = 3'd0;
    localparam logic [2:0] OP_WR_SWAP    = 3'd1;
    localparam logic [2:0] OP_FLAGS_ONLY = 3'd2;
    localparam logic [2:0] OP_LD_SR      = 3'd3;
    localparam logic [2:0] OP_XOR_SR     = 3'd4;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [19:0]   r_wr_data;
    logic [2:0]    r_sr;
    logic          r_illegal;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_pend_addr;
    logic [19:0]   r_pend_data;

    logic          w_accept;
    logic          w_write_a;
    logic          w_swap_split;
    logic          w_illegal_op;
    logic [19:0]   w_res_a_m;
    logic [19:0]   w_res_b_m;
    logic [2:0]    w_flags;
    logic [2:0]    w_sr_flagged;
    logic [2:0]    w_sr_nxt;

    assign in_ready     = (r_state == S_IDLE) && !rst;
    assign w_accept     = in_valid && in_ready;
    assign w_write_a    = w_accept && ((in_op == OP_WR_ONE) || (in_op == OP_WR_SWAP));
    assign w_swap_split = w_accept && (in_op == OP_WR_SWAP) && (in_dst_a != in_dst_b);
    assign w_illegal_op = (in_op > OP_XOR_SR);

    // Half-word mode passes only the low 10 bits of either result.
    assign w_res_a_m = in_mode ? in_res_a : {10'b0, in_res_a[9:0]};
    assign w_res_b_m = in_mode ? in_res_b : {10'b0, in_res_b[9:0]};

    assign w_flags      = {in_carry, in_sign, in_zero};
    assign w_sr_flagged = (r_sr & ~in_flag_mask) | (w_flags & in_flag_mask);

    always_comb begin
        w_sr_nxt = r_sr;
        if (w_accept) begin
            case (in_op)
                OP_WR_ONE,
                OP_WR_SWAP,
                OP_FLAGS_ONLY: w_sr_nxt = w_sr_flagged;
                OP_LD_SR:      w_sr_nxt = in_res_a[2:0];
                OP_XOR_SR:     w_sr_nxt = r_sr ^ in_res_a[2:0];
                default:       w_sr_nxt = r_sr;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_swap_split) w_state_nxt = S_SECOND;
            S_SECOND: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Write port: SECOND always drains the latched B result; accepts cannot
    // collide with it because in_ready is low in SECOND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state == S_SECOND) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_pend_addr;
                r_wr_data <= r_pend_data;
            end else if (w_write_a) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= in_dst_a;
                r_wr_data <= w_res_a_m;
            end
            if (w_swap_split) begin
                r_pend_addr <= in_dst_b;
                r_pend_data <= w_res_b_m;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= 3'b000;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sr      <= w_sr_nxt;
            r_illegal <= w_accept && w_illegal_op;
            if (w_accept) r_cnt <= r_cnt + CW'(1);
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign sr         = r_sr;
    assign illegal    = r_illegal;
    assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized + directed bench for alu_writeback against a cycle-level
// transaction model of the writeback rules.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_mode;
    logic [3:0]  in_dst_a, in_dst_b;
    logic [19:0] in_res_a, in_res_b;
    logic        in_zero, in_sign, in_carry;
    logic [2:0]  in_flag_mask;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic [2:0]  sr;
    logic        illegal;
    logic [15:0] retire_cnt;

    always #5 clk = ~clk;

    alu_writeback #(.AW(4), .CW(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_mode(in_mode),
        .in_dst_a(in_dst_a), .in_dst_b(in_dst_b),
        .in_res_a(in_res_a), .in_res_b(in_res_b),
        .in_zero(in_zero), .in_sign(in_sign), .in_carry(in_carry),
        .in_flag_mask(in_flag_mask),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sr(sr), .illegal(illegal), .retire_cnt(retire_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: architectural SR, counter, and an outstanding B write.
    logic [2:0]  m_sr;
    logic [15:0] m_cnt;
    bit          m_pend;
    logic [3:0]  m_pa;
    logic [19:0] m_pd;
    int          n_wr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input logic [2:0] op, input bit md,
                       input logic [3:0] da, input logic [3:0] db,
                       input logic [19:0] ra, input logic [19:0] rb,
                       input bit z, input bit s, input bit c, input logic [2:0] mk);
        in_valid = v; in_op = op; in_mode = md; in_dst_a = da; in_dst_b = db;
        in_res_a = ra; in_res_b = rb; in_zero = z; in_sign = s; in_carry = c;
        in_flag_mask = mk;
    endtask

    task automatic model_rst();
        m_sr = 3'b000; m_cnt = 16'd0; m_pend = 0; m_pa = 4'd0; m_pd = 20'd0;
    endtask

    // Predict this edge from the currently driven bundle, advance one clock,
    // then compare everything #1 after the edge.
    task automatic cycle();
        bit          acc, was_rst, e_wen, e_ill;
        logic [3:0]  e_addr;
        logic [19:0] e_data;
        logic [2:0]  flg;
        e_wen = 0; e_ill = 0; e_addr = 0; e_data = 0;
        was_rst = rst;
        acc = in_valid && !m_pend && !rst;
        if (rst) begin
            model_rst();
        end else if (m_pend) begin
            e_wen = 1; e_addr = m_pa; e_data = m_pd; m_pend = 0;
        end else if (acc) begin
            m_cnt = m_cnt + 16'd1;
            flg = {in_carry, in_sign, in_zero};
            case (in_op)
                3'd0, 3'd1: begin
                    e_wen = 1; e_addr = in_dst_a;
                    e_data = in_mode ? in_res_a : in_res_a % 1024;
                    for (int i = 0; i < 3; i++) if (in_flag_mask[i]) m_sr[i] = flg[i];
                    if (in_op == 3'd1 && in_dst_a != in_dst_b) begin
                        m_pend = 1; m_pa = in_dst_b;
                        m_pd = in_mode ? in_res_b : in_res_b % 1024;
                    end
                end
                3'd2: for (int i = 0; i < 3; i++) if (in_flag_mask[i]) m_sr[i] = flg[i];
                3'd3: m_sr = in_res_a % 8;
                3'd4: m_sr = m_sr ^ (in_res_a % 8);
                default: e_ill = 1;
            endcase
        end
        @(posedge clk); #1;
        if (wr_en) n_wr++;
        chk("wr_en", wr_en, e_wen);
        if (e_wen || was_rst) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
        end
        chk("sr", sr, m_sr);
        chk("illegal", illegal, e_ill);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("in_ready", in_ready, !m_pend && !rst);
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        model_rst();
        n_wr = 0;
        #3;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_sr", sr, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_ready", in_ready, 0);
        #19 rst = 1'b0;
        cycle();

        // WR_ONE half-word
        drv(1, 3'd0, 0, 4'd3, 4'd0, 20'hFFFFF, 20'h0, 1, 0, 0, 3'b001);
        cycle();
        chk("w1_wr_en", wr_en, 1);
        chk("w1_addr", wr_addr, 4'd3);
        chk("w1_data", wr_data, 20'h003FF);
        chk("w1_sr", sr, 3'b001);

        // Swap distinct; a new bundle offered during SECOND must wait
        drv(1, 3'd1, 1, 4'd1, 4'd2, 20'h12345, 20'hABCDE, 0, 0, 0, 3'b000);
        cycle();
        chk("sw_a_addr", wr_addr, 4'd1);
        chk("sw_a_data", wr_data, 20'h12345);
        chk("sw_ready_lo", in_ready, 0);
        drv(1, 3'd0, 1, 4'd7, 4'd0, 20'h55555, 20'h0, 0, 0, 0, 3'b000);
        cycle();
        chk("sw_b_en", wr_en, 1);
        chk("sw_b_addr", wr_addr, 4'd2);
        chk("sw_b_data", wr_data, 20'hABCDE);
        chk("sw_cnt_hold", retire_cnt, 16'd2);
        chk("sw_ready_hi", in_ready, 1);
        cycle();
        chk("sw_next_addr", wr_addr, 4'd7);
        chk("sw_next_cnt", retire_cnt, 16'd3);

        // Swap to the same register: one write, no stall
        n_wr = 0;
        drv(1, 3'd1, 1, 4'd5, 4'd5, 20'h11111, 20'h22222, 0, 0, 0, 3'b000);
        cycle();
        chk("same_ready", in_ready, 1);
        drv(0, 3'd0, 1, 4'd0, 4'd0, 20'h0, 20'h0, 0, 0, 0, 3'b000);
        cycle();
        cycle();
        chk("same_nwr", n_wr, 1);

        // Reset while in SECOND drops the B write
        drv(1, 3'd1, 1, 4'd8, 4'd9, 20'h0AAAA, 20'h0BBBB, 0, 0, 0, 3'b000);
        cycle();
        in_valid = 0;
        #2 rst = 1'b1;
        model_rst();
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_ready", in_ready, 0);
        n_wr = 0;
        cycle();
        #2 rst = 1'b0;
        cycle();
        chk("midrst_nwr", n_wr, 0);

        // SR ops back to back
        drv(1, 3'd3, 1, 4'd0, 4'd0, 20'h00005, 20'h0, 0, 0, 0, 3'b000);
        cycle();
        chk("ldsr", sr, 3'b101);
        drv(1, 3'd4, 1, 4'd0, 4'd0, 20'h00003, 20'h0, 0, 0, 0, 3'b000);
        cycle();
        chk("xorsr", sr, 3'b110);
        drv(1, 3'd2, 1, 4'd0, 4'd0, 20'h0, 20'h0, 1, 0, 1, 3'b010);
        cycle();
        chk("flagsonly", sr, 3'b100);

        // Illegal op
        drv(1, 3'd6, 1, 4'd4, 4'd4, 20'hFFFFF, 20'hFFFFF, 1, 1, 1, 3'b111);
        cycle();
        chk("ill_pulse", illegal, 1);
        chk("ill_wr_en", wr_en, 0);
        chk("ill_sr", sr, 3'b100);
        drv(0, 3'd0, 1, 4'd0, 4'd0, 20'h0, 20'h0, 0, 0, 0, 3'b000);
        cycle();
        chk("ill_one_cyc", illegal, 0);

        // Reset mid-run with non-zero state
        #2 rst = 1'b1;
        model_rst();
        #1;
        chk("rst2_sr", sr, 0);
        chk("rst2_cnt", retire_cnt, 0);
        chk("rst2_ill", illegal, 0);
        chk("rst2_ready", in_ready, 0);
        cycle();
        #2 rst = 1'b0;
        #1 chk("rst2_ready_rel", in_ready, 1);
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] da;
            da = 4'($urandom_range(0, 15));
            drv($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom),
                da, ($urandom_range(0, 3) == 0) ? da : 4'($urandom_range(0, 15)),
                20'($urandom), 20'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom_range(0, 7)));
            cycle();
        end

        // Counter wrap from a fresh reset
        drv(0, 3'd0, 1, 4'd0, 4'd0, 20'h0, 20'h0, 0, 0, 0, 3'b000);
        #2 rst = 1'b1;
        model_rst();
        cycle();
        #2 rst = 1'b0;
        for (int n = 0; n < 65535; n++) begin
            drv(1, 3'd2, 1, 4'd0, 4'd0, 20'h0, 20'h0, 1'($urandom), 1'($urandom),
                1'($urandom), 3'($urandom_range(0, 7)));
            cycle();
        end
        chk("cnt_max", retire_cnt, 16'hFFFF);
        cycle();
        chk("cnt_wrap", retire_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the 20-bit ALU. It accepts one ALU result bundle per handshake: results, zero/sign/carry flags, operating mode and destination indices. It drives a single-port register-file write bus and owns the architectural status register. Swap/exchange results need two register writes, so the block sequences them over two cycles and back-pressures the ALU while it does.

## Interface
Parameters:
- `AW`, 4: register-file address width (16 registers).
- `CW`, 16: retired-operation counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: result bundle valid.
- `in_ready` out 1: block can accept a bundle this cycle.
- `in_op` in 3: 0 WR_ONE, 1 WR_SWAP, 2 FLAGS_ONLY, 3 LD_SR, 4 XOR_SR, 5-7 illegal.
- `in_mode` in 1: 1 full-word (20-bit), 0 half-word (10-bit).
- `in_dst_a`, `in_dst_b` in AW: destination registers for result A and result B.
- `in_res_a`, `in_res_b` in 20: ALU results (`out_a`/`out_b` for swap).
- `in_zero`, `in_sign`, `in_carry` in 1: ALU flags.
- `in_flag_mask` in 3: per-flag update enable, {carry, sign, zero}.
- `wr_en` out 1: register-file write strobe.
- `wr_addr` out AW: write address.
- `wr_data` out 20: write data.
- `sr` out 3: status register {carry, sign, zero}.
- `illegal` out 1: one-cycle pulse when an illegal op is accepted.
- `retire_cnt` out CW: count of accepted bundles.

## Operation
- Accept = `in_valid && in_ready` at a rising edge. `in_ready` = (state == IDLE) && !`rst`. It is combinational from state only, with no dependence on `in_valid`.
- States are IDLE and SECOND. Reset enters IDLE.
- Half-word masking: when `in_mode`=0, `wr_data`[19:10] is forced to 0 on every write. Only [9:0] of the result passes.
- **WR_ONE:** write `in_res_a` to `in_dst_a`. For each bit set in `in_flag_mask`, the corresponding `sr` bit takes the ALU flag. Stay in IDLE.
- **WR_SWAP:** write A to `in_dst_a` and apply the flag update, then latch the masked `in_res_b` and `in_dst_b`. Go to SECOND. In SECOND, write B, then return to IDLE.
  - If `in_dst_a` == `in_dst_b`, only the A write occurs and the block stays in IDLE.
- **FLAGS_ONLY:** no write; masked flag update only. Used by compare ops.
- **LD_SR:** `sr` <= `in_res_a`[2:0]. `in_flag_mask` and ALU flags are ignored. No write.
- **XOR_SR:** `sr` <= `sr` ^ `in_res_a`[2:0]. No write.
- **Illegal (5-7):** no write and `sr` unchanged. `illegal` pulses for one cycle. The bundle still counts as retired.
- `retire_cnt` increments by 1 on every accept, including illegal ops, and wraps from 2^CW-1 to 0. A swap counts once.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `sr`=3'b000, `illegal`=0, `retire_cnt`=0, state IDLE.
- Reset mid-swap (during SECOND) drops the pending B write. `wr_en` is 0 from reset assertion onward.

## Timing
- `wr_en`, `wr_addr`, `wr_data` and `illegal` are registered.
  - For a bundle accepted at edge N, the A write is visible in the cycle after edge N.
  - The swap B write is visible in the cycle after edge N+1.
  - `wr_en` is otherwise 0 and is never held for more than one cycle per write.
- `sr` and `retire_cnt` update at the accept edge and are visible the following cycle.
- Throughput:
  - One bundle per cycle for all ops except WR_SWAP with distinct destinations.
  - WR_SWAP with distinct destinations holds `in_ready` low for exactly one cycle (SECOND). The next accept is possible at edge N+2.
- Back-to-back accepts: each edge's `sr` update uses the `sr` value produced by the previous edge. XOR_SR after FLAGS_ONLY therefore sees the new flags.
- While `in_ready`=0, `in_valid` and the bundle are ignored. The upstream stage holds them.
- Asynchronous reset takes effect immediately, without waiting for `clk`. Release is synchronous to the next edge.

## Test plan
- **Reset:** assert `rst` mid-run → all outputs at reset values immediately, `in_ready`=0 while asserted, `in_ready`=1 the cycle after release.
- **WR_ONE half-word:** `in_mode`=0, `in_res_a`=20'hFFFFF, `in_dst_a`=3, mask=3'b001, `in_zero`=1 → next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=20'h003FF, `sr`=3'b001.
- **Swap distinct:** WR_SWAP, A=20'h12345 to r1, B=20'hABCDE to r2, full mode → r1 write cycle N+1, r2 write cycle N+2, `in_ready`=0 only in cycle N+1, and a bundle presented during N+1 is not accepted until edge N+2.
- **Swap same register and reset mid-swap:**
  - Swap with `in_dst_a`=`in_dst_b`=5 → exactly one write and `in_ready` never drops.
  - Reset asserted in SECOND → no B write.
- **SR ops:** LD_SR `in_res_a`=3'b101 → `sr`=101, then XOR_SR 3'b011 back-to-back → `sr`=110, then FLAGS_ONLY mask=3'b010 `in_sign`=0 → `sr`=100.
- **Illegal op and counter wrap:**
  - `in_op`=6 → `illegal` high for one cycle, no `wr_en`, `sr` unchanged.
  - Preload `retire_cnt` to 16'hFFFF via 65535 accepts, then one more accept → 0.
